pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage buffer that replaces the single-entry stage register between any two pipeline stages (IF→ID, ID→EX, EX→ME, ME→WB). It holds up to DEPTH in-order bus payloads, speaks the existing Valid / Allow_in handshake on both sides, and supports a per-stage ready_go gate and a synchronous flush for branch redirect. DEPTH=1 reproduces the classic stage-register behaviour. DEPTH≥2 decouples a stalled downstream stage from upstream for DEPTH−1 extra cycles.

## Interface
Parameters:
- BUS_W, default 64: payload width in bits, ≥1.
- DEPTH, default 1: entry count, 1..8; non-power-of-2 allowed.
- CNT_W, default $clog2(DEPTH+1): occupancy width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  upstream has a payload (Prev_to_This_Valid).
- in_bus  in  BUS_W  upstream payload.
- allow_in  out  1  this buffer accepts a payload this cycle (This_Allow_in).
- ready_go  in  1  the head entry's stage work is complete.
- out_valid  out  1  head entry offered downstream (This_to_Next_Valid).
- out_bus  out  BUS_W  head entry payload.
- next_allow_in  in  1  downstream accepts (Next_Allow_in).
- flush  in  1  discard all entries and any incoming payload this cycle.
- count  out  CNT_W  current occupancy.
- head_valid  out  1  buffer non-empty, regardless of ready_go; used for hazard/forwarding qualification.
- stall_cnt  out  32  stall counter; present only with PIPE_BUF_STALL_CNT_EN.

## Operation
- Storage: circular array of DEPTH entries with rd_ptr, wr_ptr (0..DEPTH−1) and count (0..DEPTH). Pointers wrap from DEPTH−1 to 0.
- Signals:
  - empty = (count==0); full = (count==DEPTH).
  - head_valid = !empty.
  - out_valid = !empty && ready_go.
  - out_bus = entry[rd_ptr]. Undefined content is masked only by out_valid; the array resets to 0.
- pop = out_valid && next_allow_in.
- allow_in = !full || pop. A pop frees the slot the same cycle, so DEPTH=1 gives !valid || (ready_go && next_allow_in).
- push = in_valid && allow_in && !flush.
- Per-cycle update:
  - push only: write entry[wr_ptr], wr_ptr++ (wrapping), count++.
  - pop only: rd_ptr++ (wrapping), count−−.
  - push and pop: both pointers advance, count unchanged. Legal when full.
  - neither: hold.
- Flush has priority over everything. Next cycle: count=0, rd_ptr=wr_ptr=0, no push. Downstream may still sample out_valid/out_bus during the flush cycle, and a pop in that cycle is honoured by downstream; the buffer side simply empties.
- Reset has priority over flush. Reset mid-operation drops all entries.
- Ordering: strict FIFO. No payload modification, duplication or loss, except on flush or reset.

## Timing
- Reset values: allow_in=1, out_valid=0, head_valid=0, out_bus=0, count=0, stall_cnt=0.
- Latency: a payload pushed in cycle N is visible at out_bus/head_valid in cycle N+1. There is no combinational in→out path.
- Throughput: 1 payload/cycle sustained when ready_go=1 and next_allow_in=1, for any DEPTH.
- Combinational paths:
  - allow_in depends on next_allow_in and ready_go.
  - out_valid depends on ready_go.
  - No path from in_valid or in_bus to any output.
- Upstream contract: in_bus must be stable whenever in_valid=1 and allow_in=0. The buffer does not check this.

## Configuration
- PIPE_BUF_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - It increments by 1 each cycle that head_valid=1 and pop=0, saturating at 0xFFFFFFFF.
  - It clears on reset only, not on flush.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- DEPTH=1 streaming: reset, then in_valid=1 with in_bus=1,2,3…, ready_go=1, next_allow_in=1 → out_bus 1,2,3 one cycle later, one per cycle; allow_in stays 1; count stays 1.
- DEPTH=3 backpressure: next_allow_in=0, push A,B,C → count 1,2,3, then allow_in=0. Further in_valid is ignored. Release next_allow_in → A,B,C pop in order; allow_in=1 in the first release cycle.
- Full with simultaneous push/pop (DEPTH=3): full, next_allow_in=1, push D → A popped, D accepted, count stays 3. Repeat 5 cycles → pointer wrap verified, order A,B,C,D,E,F…
- ready_go gate: head X present, ready_go=0 for 4 cycles with next_allow_in=1 → out_valid=0, head_valid=1, no pop. With the macro, stall_cnt=4. Set ready_go=1 → X pops.
- Flush: DEPTH=4, count=3, assert flush with in_valid=1 → next cycle count=0, head_valid=0, incoming payload dropped. A subsequent push of Y emerges as the first output.
- Reset mid-stream: count=2, assert reset 1 cycle → all outputs at reset values. The next pushed payload is the first output.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: DEPTH-entry in-order FIFO speaking the Valid / Allow_in handshake.
// Optional stall counter output enabled by defining PIPE_BUF_STALL_CNT_EN.
module pipe_stage_buf #(
  parameter  int BUS_W = 64,
  parameter  int DEPTH = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_bus,
  output logic             allow_in,
  input  logic             ready_go,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_bus,
  input  logic             next_allow_in,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid
`ifdef PIPE_BUF_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BUS_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic empty_s;
  logic full_s;
  logic out_valid_s;
  logic pop_s;
  logic allow_in_s;
  logic push_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake decode; a pop frees its slot in the same cycle.
  always_comb begin
    empty_s     = (count_r == CNT_W'(0));
    full_s      = (count_r == CNT_W'(DEPTH));
    out_valid_s = !empty_s && ready_go;
    pop_s       = out_valid_s && next_allow_in;
    allow_in_s  = !full_s || pop_s;
    push_s      = in_valid && allow_in_s && !flush;
  end

  assign allow_in   = allow_in_s;
  assign out_valid  = out_valid_s;
  assign out_bus    = mem_r[rd_ptr_r];
  assign count      = count_r;
  assign head_valid = !empty_s;

  // Storage, pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_bus;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef PIPE_BUF_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles a head entry sits without leaving; survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (!empty_s && !pop_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: DEPTH=1 and DEPTH=3 instances share one stimulus,
// checked by directed vector tables and a queue-based reference model under random stimulus.
module tb_pipe_stage_buf;

  localparam int BW = 16;

  typedef logic [BW-1:0] bus_q_t[$];

  typedef struct {
    logic          rst, fl, iv;
    logic [BW-1:0] ib;
    logic          rg, na;
    logic          e_ai, e_ov, e_hv;
    int            e_cnt;
    logic [BW-1:0] e_ob;
    logic          chk_ob;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, ready_go, next_allow_in, flush;
  logic [BW-1:0] in_bus;

  logic          ai1, ov1, hv1, ai3, ov3, hv3;
  logic [BW-1:0] ob1, ob3;
  logic [0:0]    cnt1;
  logic [1:0]    cnt3;
  logic [31:0]   sc1, sc3;

  int total = 0;
  int bad   = 0;

  pipe_stage_buf #(.BUS_W(BW), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus), .allow_in(ai1),
    .ready_go(ready_go), .out_valid(ov1), .out_bus(ob1), .next_allow_in(next_allow_in),
    .flush(flush), .count(cnt1), .head_valid(hv1)
`ifdef PIPE_BUF_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );

  pipe_stage_buf #(.BUS_W(BW), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus), .allow_in(ai3),
    .ready_go(ready_go), .out_valid(ov3), .out_bus(ob3), .next_allow_in(next_allow_in),
    .flush(flush), .count(cnt3), .head_valid(hv3)
`ifdef PIPE_BUF_STALL_CNT_EN
    , .stall_cnt(sc3)
`endif
  );

`ifndef PIPE_BUF_STALL_CNT_EN
  assign sc1 = 32'd0;
  assign sc3 = 32'd0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, fl, iv, input logic [BW-1:0] ib,
                              input logic rg, na, ai, ov, hv, input int cnt,
                              input logic [BW-1:0] ob, input logic cob);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ib = ib; v.rg = rg; v.na = na;
    v.e_ai = ai; v.e_ov = ov; v.e_hv = hv; v.e_cnt = cnt; v.e_ob = ob; v.chk_ob = cob;
    return v;
  endfunction

  // Reference: the buffer is just a bounded queue; compare then advance one cycle.
  task automatic model_cmp(input string nm, input int dep, input bus_q_t q, input logic [31:0] s,
                           input logic ai, ov, hv, input logic [63:0] cnt,
                           input logic [BW-1:0] ob, input logic [31:0] sc,
                           output bus_q_t qn, output logic [31:0] sn);
    logic e_hv, e_ov, e_pop, e_ai, e_push;
    e_hv   = (q.size() != 0);
    e_ov   = e_hv && ready_go;
    e_pop  = e_ov && next_allow_in;
    e_ai   = (q.size() < dep) || e_pop;
    e_push = in_valid && e_ai && !flush;
    chk({nm, " allow_in"},   {63'd0, ai}, {63'd0, e_ai});
    chk({nm, " out_valid"},  {63'd0, ov}, {63'd0, e_ov});
    chk({nm, " head_valid"}, {63'd0, hv}, {63'd0, e_hv});
    chk({nm, " count"},      cnt, 64'(q.size()));
    if (e_hv) chk({nm, " out_bus"}, 64'(ob), 64'(q[0]));
`ifdef PIPE_BUF_STALL_CNT_EN
    chk({nm, " stall_cnt"}, 64'(sc), 64'(s));
`endif
    qn = q;
    sn = s;
    if (e_hv && !e_pop && s != 32'hFFFF_FFFF) sn = s + 32'd1;
    if (reset) begin
      qn = {};
      sn = 32'd0;
    end else if (flush) begin
      qn = {};
    end else begin
      if (e_pop)  void'(qn.pop_front());
      if (e_push) qn.push_back(in_bus);
    end
  endtask

  vec_t   vt[28];
  bus_q_t q1, q3, nq;
  logic [31:0] s1, s3, ns;

  initial begin
    // rst fl iv ib rg na | ai ov hv cnt ob chk_ob   (checked against DEPTH=3 instance)
    vt[0]  = mk(0,0,1,16'h000A,1,0, 1,0,0,0,16'h0000,0);
    vt[1]  = mk(0,0,1,16'h000B,1,0, 1,1,1,1,16'h000A,1);
    vt[2]  = mk(0,0,1,16'h000C,1,0, 1,1,1,2,16'h000A,1);
    vt[3]  = mk(0,0,1,16'h0099,1,0, 0,1,1,3,16'h000A,1);
    vt[4]  = mk(0,0,1,16'h000D,1,1, 1,1,1,3,16'h000A,1);
    vt[5]  = mk(0,0,1,16'h000E,1,1, 1,1,1,3,16'h000B,1);
    vt[6]  = mk(0,0,1,16'h000F,1,1, 1,1,1,3,16'h000C,1);
    vt[7]  = mk(0,0,1,16'h0010,1,1, 1,1,1,3,16'h000D,1);
    vt[8]  = mk(0,0,1,16'h0011,1,1, 1,1,1,3,16'h000E,1);
    vt[9]  = mk(0,0,0,16'h0000,1,1, 1,1,1,3,16'h000F,1);
    vt[10] = mk(0,0,0,16'h0000,1,1, 1,1,1,2,16'h0010,1);
    vt[11] = mk(0,0,0,16'h0000,0,1, 1,0,1,1,16'h0011,1);
    vt[12] = mk(0,0,0,16'h0000,0,1, 1,0,1,1,16'h0011,1);
    vt[13] = mk(0,0,0,16'h0000,0,1, 1,0,1,1,16'h0011,1);
    vt[14] = mk(0,0,0,16'h0000,0,1, 1,0,1,1,16'h0011,1);
    vt[15] = mk(0,0,0,16'h0000,1,1, 1,1,1,1,16'h0011,1);
    vt[16] = mk(0,0,1,16'h0021,1,0, 1,0,0,0,16'h0000,0);
    vt[17] = mk(0,0,1,16'h0022,1,0, 1,1,1,1,16'h0021,1);
    vt[18] = mk(0,1,1,16'h0023,1,0, 1,1,1,2,16'h0021,1);
    vt[19] = mk(0,0,1,16'h0030,1,0, 1,0,0,0,16'h0000,0);
    vt[20] = mk(0,0,0,16'h0000,1,1, 1,1,1,1,16'h0030,1);
    vt[21] = mk(0,0,1,16'h0041,1,0, 1,0,0,0,16'h0000,0);
    vt[22] = mk(0,0,1,16'h0042,1,0, 1,1,1,1,16'h0041,1);
    vt[23] = mk(1,0,1,16'h0043,1,0, 1,1,1,2,16'h0041,1);
    vt[24] = mk(0,0,0,16'h0000,1,0, 1,0,0,0,16'h0000,1);
    vt[25] = mk(0,0,1,16'h0050,1,0, 1,0,0,0,16'h0000,0);
    vt[26] = mk(0,0,0,16'h0000,1,1, 1,1,1,1,16'h0050,1);
    vt[27] = mk(0,0,0,16'h0000,1,1, 1,0,0,0,16'h0000,0);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bus = '0; ready_go = 1'b0; next_allow_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst d1 allow_in", {63'd0, ai1}, 64'd1);
    chk("rst d1 out_valid", {63'd0, ov1}, 64'd0);
    chk("rst d1 head_valid", {63'd0, hv1}, 64'd0);
    chk("rst d1 count", 64'(cnt1), 64'd0);
    chk("rst d1 out_bus", 64'(ob1), 64'd0);
    chk("rst d3 allow_in", {63'd0, ai3}, 64'd1);
    chk("rst d3 out_valid", {63'd0, ov3}, 64'd0);
    chk("rst d3 count", 64'(cnt3), 64'd0);
    chk("rst d3 out_bus", 64'(ob3), 64'd0);
`ifdef PIPE_BUF_STALL_CNT_EN
    chk("rst d3 stall_cnt", 64'(sc3), 64'd0);
`endif

    // DEPTH=1 streaming: one payload per cycle, one cycle of latency
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_bus = BW'(i); ready_go = 1'b1; next_allow_in = 1'b1;
      #1;
      chk("stream d1 allow_in", {63'd0, ai1}, 64'd1);
      chk("stream d1 count", 64'(cnt1), (i == 1) ? 64'd0 : 64'd1);
      if (i > 1) begin
        chk("stream d1 out_valid", {63'd0, ov1}, 64'd1);
        chk("stream d1 out_bus", 64'(ob1), 64'(i - 1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stream d1 last out_bus", 64'(ob1), 64'd6);
    chk("stream d1 last count", 64'(cnt1), 64'd1);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);

    // Directed DEPTH=3 table: backpressure, full push+pop wrap, ready_go gate, flush, reset
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      reset = vt[i].rst; flush = vt[i].fl; in_valid = vt[i].iv; in_bus = vt[i].ib;
      ready_go = vt[i].rg; next_allow_in = vt[i].na;
      #1;
      chk($sformatf("vec%0d allow_in", i),   {63'd0, ai3}, {63'd0, vt[i].e_ai});
      chk($sformatf("vec%0d out_valid", i),  {63'd0, ov3}, {63'd0, vt[i].e_ov});
      chk($sformatf("vec%0d head_valid", i), {63'd0, hv3}, {63'd0, vt[i].e_hv});
      chk($sformatf("vec%0d count", i),      64'(cnt3), 64'(vt[i].e_cnt));
      if (vt[i].chk_ob) chk($sformatf("vec%0d out_bus", i), 64'(ob3), 64'(vt[i].e_ob));
    end

    // Random stimulus against the queue model, both depths
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    q1 = {}; q3 = {}; s1 = 32'd0; s3 = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 63) == 0);
      flush         = ($urandom_range(0, 31) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_bus        = BW'($urandom);
      ready_go      = ($urandom_range(0, 4) != 0);
      next_allow_in = ($urandom_range(0, 2) != 0);
      #1;
      model_cmp("rnd d1", 1, q1, s1, ai1, ov1, hv1, 64'(cnt1), ob1, sc1, nq, ns);
      q1 = nq; s1 = ns;
      model_cmp("rnd d3", 3, q3, s3, ai3, ov3, hv3, 64'(cnt3), ob3, sc3, nq, ns);
      q3 = nq; s3 = ns;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
